// File: rtl/risc_toy_mem_arbiter_pkg.sv
// Shared constants for the unified RISC_TOY instruction/data memory arbiter.
package risc_toy_mem_pkg;
  localparam int MEM_AW = 10;
  localparam int MEM_DW = 32;

  // Read-return owner: whose RVALID fires in the cycle after an access
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
endpackage

// File: rtl/risc_toy_mem_arbiter_if.sv
// CPU I/D request ports plus single-port SRAM pins as one bundle.
interface risc_toy_mem_arbiter_if
  import risc_toy_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
);
  logic          I_REQ;
  logic [29:0]   I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ;
  logic          D_RW;
  logic [29:0]   D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] D_RDATA;
  logic          M_CSN;
  logic [AW-1:0] M_A;
  logic          M_WEN;
  logic [DW-1:0] M_DI;
  logic [DW-1:0] M_DOUT;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, M_DOUT,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    output M_CSN, M_A, M_WEN, M_DI
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, M_DOUT,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    input  M_CSN, M_A, M_WEN, M_DI
  );
endinterface

// File: rtl/risc_toy_mem_arbiter_mem_rdata_hold.sv
// Per-port read-data register: passes SRAM data through on RVALID, holds it after.
module mem_rdata_hold
  import risc_toy_mem_pkg::*;
#(
  parameter int DW = MEM_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rvalid_i,
  input  logic [DW-1:0] dout_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       hold_q <= '0;
    else if (rvalid_i) hold_q <= dout_i;
  end

  assign rdata_o = rvalid_i ? dout_i : hold_q;
endmodule

// File: rtl/risc_toy_mem_arbiter.sv
// Arbitrates the I (read-only) and D (read/write) ports onto one synchronous SRAM;
// D has priority, but I is boosted after STARVE_MAX consecutive D wins.
module risc_toy_mem_arbiter
  import risc_toy_mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int STARVE_MAX = 4
) (
  input logic                   CLK,
  input logic                   RSTN,
  risc_toy_mem_arbiter_if.slave bus
);
  localparam int CW        = $clog2(STARVE_MAX + 1);
  localparam int NUM_PORTS = 2;
  localparam int P_I       = 0;
  localparam int P_D       = 1;

  logic [CW-1:0] starve_q, starve_d;
  logic [1:0]    own_q, own_d;
  logic [AW-1:0] ma_q, ma_d;
  logic [DW-1:0] mdi_q, mdi_d;
  logic          boost, i_gnt, d_gnt;
  logic [NUM_PORTS-1:0]         rvld;
  logic [NUM_PORTS-1:0][DW-1:0] rdata;
  logic          unused_addr;

  assign boost = (starve_q == CW'(STARVE_MAX));

  // Grants are masked while reset is asserted so no access leaks out of reset
  always_comb begin
    d_gnt = RSTN & bus.D_REQ & ~(bus.I_REQ & boost);
    i_gnt = RSTN & bus.I_REQ & ~d_gnt;
  end

  always_comb begin
    ma_d     = ma_q;
    mdi_d    = mdi_q;
    own_d    = OWN_NONE;
    starve_d = starve_q;
    if (d_gnt) begin
      ma_d = bus.D_ADDR[AW+1:2];
      if (bus.D_RW) mdi_d = bus.D_WDATA;
      else          own_d = OWN_D;
    end else if (i_gnt) begin
      ma_d  = bus.I_ADDR[AW+1:2];
      own_d = OWN_I;
    end
    if (i_gnt || !bus.I_REQ)  starve_d = '0;
    else if (d_gnt && !boost) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      starve_q <= '0;
      own_q    <= OWN_NONE;
      ma_q     <= '0;
      mdi_q    <= '0;
    end else begin
      starve_q <= starve_d;
      own_q    <= own_d;
      ma_q     <= ma_d;
      mdi_q    <= mdi_d;
    end
  end

  // Idle cycles leave M_A/M_DI at their last driven values
  assign bus.M_CSN = ~(i_gnt | d_gnt);
  assign bus.M_WEN = ~(d_gnt & bus.D_RW);
  assign bus.M_A   = ma_d;
  assign bus.M_DI  = mdi_d;
  assign bus.I_GNT = i_gnt;
  assign bus.D_GNT = d_gnt;

  assign rvld[P_I] = (own_q == OWN_I);
  assign rvld[P_D] = (own_q == OWN_D);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_hold
    mem_rdata_hold #(.DW(DW)) u_hold (
      .clk_i   (CLK),
      .rst_ni  (RSTN),
      .rvalid_i(rvld[p]),
      .dout_i  (bus.M_DOUT),
      .rdata_o (rdata[p])
    );
  end

  assign bus.I_RVALID = rvld[P_I];
  assign bus.D_RVALID = rvld[P_D];
  assign bus.I_RDATA  = rdata[P_I];
  assign bus.D_RDATA  = rdata[P_D];

  assign unused_addr = ^{bus.I_ADDR[29:AW+2], bus.I_ADDR[1:0],
                         bus.D_ADDR[29:AW+2], bus.D_ADDR[1:0]};
endmodule
